program_loader: RTL

Upstream boot stage for the 8-bit CPU. Accepts a framed program image as a byte stream over a valid/ready handshake, writes it into the CPU's 64-entry instruction/data RAM through the RAM write port (`Data_w`, `ram_we`, address), and holds the CPU in reset until a complete image with a valid checksum has been stored. On success it releases the CPU to run from the loaded image. On error it keeps the CPU held and flags the failure.

---
 rtl/program_loader.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/program_loader.sv
// program_loader
// Boot-stage loader for the 8-bit CPU. It accepts a framed program image
// (LEN, LEN data bytes, CHK) over a valid/ready byte stream and writes the
// data bytes into the CPU RAM. The CPU is held in reset until a complete
// frame with a good checksum has been stored.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   start                one-cycle request to begin a new load (ignored while busy)
//   in_valid/in_data     byte stream from upstream
//   in_ready             loader accepts a byte this cycle (decoded from state only)
//   ram_we/ram_addr/ram_data  registered RAM write port (one cycle per byte)
//   cpu_rst              CPU reset, low only after a successful load
//   busy/done/error      frame in progress / last load good / last load bad
//   byte_count           data bytes accepted in the current or last frame
module program_loader #(
    parameter int ADDR_W    = 6,
    parameter int DEPTH     = 64,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_data,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   byte_count
);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN, S_DATA, S_CHECK, S_DONE, S_ERROR
    } state_t;

    localparam logic [ADDR_W-1:0] PTR_BASE = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);
    localparam logic [8:0]        LEN_MAX  = 9'(DEPTH);

    state_t              state_q, state_d;
    logic [ADDR_W:0]     len_q, len_d;
    logic [7:0]          sum_q, sum_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [ADDR_W:0]     cnt_q, cnt_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [7:0]          data_q, data_d;

    logic                xfer;
    logic [7:0]          chk_sum;
    logic [ADDR_W:0]     cnt_inc;

    // in_ready depends only on the state register, never on in_valid.
    assign in_ready   = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CHECK);
    assign busy       = in_ready;
    assign done       = (state_q == S_DONE);
    assign error      = (state_q == S_ERROR);
    assign cpu_rst    = (state_q != S_DONE);
    assign ram_we     = we_q;
    assign ram_addr   = addr_q;
    assign ram_data   = data_q;
    assign byte_count = cnt_q;

    assign xfer    = in_valid && in_ready;
    assign chk_sum = sum_q + in_data;
    assign cnt_inc = cnt_q + (ADDR_W+1)'(1);

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        sum_d   = sum_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_d = S_LEN;
                    cnt_d   = '0;
                end
            end
            S_LEN: begin
                if (xfer) begin
                    if (in_data == 8'd0 || {1'b0, in_data} > LEN_MAX) begin
                        state_d = S_ERROR;
                    end else begin
                        len_d   = in_data[ADDR_W:0];
                        sum_d   = 8'd0;
                        ptr_d   = PTR_BASE;
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (xfer) begin
                    we_d   = 1'b1;
                    addr_d = ptr_q;
                    data_d = in_data;
                    sum_d  = chk_sum;
                    // Pointer wraps at DEPTH, which need not be a power of two.
                    ptr_d  = (ptr_q == PTR_LAST) ? '0 : ptr_q + ADDR_W'(1);
                    cnt_d  = cnt_inc;
                    if (cnt_inc == len_q) state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (xfer) state_d = (chk_sum == 8'd0) ? S_DONE : S_ERROR;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            sum_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            sum_q   <= sum_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

endmodule
